// File: rtl/buzzer_event_monitor.sv
// Receive-side monitor for the one-hot buzzer alarm lines: measures each pulse,
// flags malformed activity and queues {zone, err} events in a show-ahead FIFO.
module buzzer_event_monitor #(
  parameter int unsigned PULSE_LEN  = 31,
  parameter int unsigned TOL        = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [2:0]       buzz_in,
  input  logic             rd_en,
  output logic             evt_valid,
  output logic [1:0]       evt_zone,
  output logic             evt_err,
  output logic             fifo_full,
  output logic             overflow,
  output logic [CNT_W-1:0] alarm_cnt
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [5:0]  LEN_MIN = 6'(PULSE_LEN - TOL);
  localparam logic [5:0]  LEN_MAX = 6'(PULSE_LEN + TOL);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_WAIT_CLR} state_t;

  state_t     r_state, w_state_nxt;
  logic [5:0] r_len, w_len_nxt;
  logic [1:0] r_zone, w_zone_nxt;

  logic       w_onehot;
  logic [1:0] w_in_zone;
  logic [2:0] w_hot_latched;

  logic       w_push;
  logic [1:0] w_push_zone;
  logic       w_push_err;

  logic [2:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_alarm_cnt;
  logic             w_pop, w_full, w_wr;

  assign w_onehot = $onehot(buzz_in);

  always_comb begin
    w_in_zone = 2'd0;
    case (buzz_in)
      3'b001:  w_in_zone = 2'd1;
      3'b010:  w_in_zone = 2'd2;
      3'b100:  w_in_zone = 2'd3;
      default: w_in_zone = 2'd0;
    endcase
  end

  always_comb begin
    w_hot_latched = 3'b000;
    case (r_zone)
      2'd1:    w_hot_latched = 3'b001;
      2'd2:    w_hot_latched = 3'b010;
      2'd3:    w_hot_latched = 3'b100;
      default: w_hot_latched = 3'b000;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_zone  <= '0;
    end else if (ena) begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_zone  <= w_zone_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_zone_nxt  = r_zone;
    unique case (r_state)
      ST_IDLE: begin
        if (w_onehot) begin
          w_zone_nxt  = w_in_zone;
          w_len_nxt   = 6'd1;
          w_state_nxt = ST_MEASURE;
        end else if (buzz_in != '0) begin
          w_state_nxt = ST_WAIT_CLR;
        end
      end
      ST_MEASURE: begin
        if (buzz_in == w_hot_latched) begin
          // Stuck line: the increment would pass the window, so the pulse ends here.
          if (r_len >= LEN_MAX) w_state_nxt = ST_WAIT_CLR;
          else                  w_len_nxt   = (r_len == '1) ? r_len : r_len + 6'd1;
        end else if (buzz_in == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_CLR;
        end
      end
      ST_WAIT_CLR: begin
        if (buzz_in == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Event generation
  always_comb begin
    w_push      = 1'b0;
    w_push_zone = r_zone;
    w_push_err  = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        if (buzz_in != '0 && !w_onehot) begin
          w_push      = 1'b1;
          w_push_zone = 2'd0;
        end
      end
      ST_MEASURE: begin
        if (buzz_in == w_hot_latched) begin
          w_push = (r_len >= LEN_MAX);
        end else begin
          w_push = 1'b1;
          if (buzz_in == '0) w_push_err = (r_len < LEN_MIN) || (r_len > LEN_MAX);
        end
      end
      default: ;
    endcase
  end

  assign w_pop  = rd_en && evt_valid;
  assign w_full = (r_count == DEPTH_C);
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (ena && w_wr) r_mem[r_wptr] <= {w_push_zone, w_push_err};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_alarm_cnt <= '0;
    end else if (ena) begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (AW+1)'(1);
      if (w_push && !w_wr) r_overflow <= 1'b1;
      if (w_wr && !w_push_err && r_alarm_cnt != '1) r_alarm_cnt <= r_alarm_cnt + CNT_W'(1);
    end
  end

  assign evt_valid = (r_count != '0);
  assign evt_zone  = evt_valid ? r_mem[r_rptr][2:1] : 2'd0;
  assign evt_err   = evt_valid ? r_mem[r_rptr][0]   : 1'b0;
  assign fifo_full = w_full;
  assign overflow  = r_overflow;
  assign alarm_cnt = r_alarm_cnt;

endmodule

// File: tb/tb_buzzer_event_monitor.sv
// Bench for buzzer_event_monitor: directed scenarios plus random pulses, all
// outputs compared every cycle against a queue-based event model.
module tb_buzzer_event_monitor;

  localparam int unsigned PULSE_LEN = 31;
  localparam int unsigned TOL       = 1;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned CNT_W     = 8;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic [2:0]       buzz_in;
  logic             rd_en;
  logic             evt_valid;
  logic [1:0]       evt_zone;
  logic             evt_err;
  logic             fifo_full;
  logic             overflow;
  logic [CNT_W-1:0] alarm_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  buzzer_event_monitor #(
    .PULSE_LEN (PULSE_LEN),
    .TOL       (TOL),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .buzz_in  (buzz_in),
    .rd_en    (rd_en),
    .evt_valid(evt_valid),
    .evt_zone (evt_zone),
    .evt_err  (evt_err),
    .fifo_full(fifo_full),
    .overflow (overflow),
    .alarm_cnt(alarm_cnt)
  );

  // Reference: mode 0 = quiet, 1 = timing a pulse, 2 = waiting for all-quiet.
  int         m_mode;
  int         m_run;
  int         m_zone;
  logic [2:0] m_q[$];
  bit         m_ovf;
  int         m_cnt;

  function automatic void model_reset();
    m_mode = 0; m_run = 0; m_zone = 0;
    m_q.delete();
    m_ovf = 0; m_cnt = 0;
  endfunction

  function automatic void model_edge(input logic [2:0] b, input logic rd, input logic en);
    bit         have;
    int         pz;
    bit         pe;
    bit         pop;
    logic [2:0] hot;
    have = 0; pz = 0; pe = 0;
    if (!en) return;
    pop = rd && (m_q.size() > 0);
    hot = 3'b001 << (m_zone - 1);
    case (m_mode)
      0: begin
        if ($countones(b) == 1) begin
          m_zone = b[0] ? 1 : (b[1] ? 2 : 3);
          m_run  = 1;
          m_mode = 1;
        end else if (b != 3'b000) begin
          have = 1; pz = 0; pe = 1; m_mode = 2;
        end
      end
      1: begin
        if (b == hot) begin
          if (m_run + 1 > int'(PULSE_LEN + TOL)) begin
            have = 1; pz = m_zone; pe = 1; m_mode = 2;
          end else begin
            m_run++;
          end
        end else if (b == 3'b000) begin
          have = 1; pz = m_zone;
          pe = !(m_run >= int'(PULSE_LEN - TOL) && m_run <= int'(PULSE_LEN + TOL));
          m_mode = 0;
        end else begin
          have = 1; pz = m_zone; pe = 1; m_mode = 2;
        end
      end
      default: if (b == 3'b000) m_mode = 0;
    endcase
    if (have && m_q.size() == DEPTH && !pop) begin
      m_ovf = 1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (have) begin
        m_q.push_back({2'(pz), pe});
        if (!pe && m_cnt < CNT_MAX) m_cnt++;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 3'b000;
    chk({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() > 0));
    chk({tag, ".zone"},  32'(evt_zone),  32'(h[2:1]));
    chk({tag, ".err"},   32'(evt_err),   32'(h[0]));
    chk({tag, ".full"},  32'(fifo_full), 32'(m_q.size() == DEPTH));
    chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, ".cnt"},   32'(alarm_cnt), 32'(m_cnt));
  endtask

  task automatic step(input logic [2:0] b, input logic rd, input logic en, input string tag);
    buzz_in = b; rd_en = rd; ena = en;
    @(posedge clk);
    model_edge(b, rd, en);
    #1;
    check_outputs(tag);
  endtask

  task automatic hold(input logic [2:0] b, input int n, input logic rd, input string tag);
    for (int i = 0; i < n; i++) step(b, rd, 1'b1, tag);
  endtask

  task automatic pulse(input int z, input int n, input string tag);
    logic [2:0] hot;
    hot = 3'b001 << (z - 1);
    hold(hot, n, 1'b0, tag);
    step(3'b000, 1'b0, 1'b1, tag);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0; buzz_in = 3'b000; rd_en = 1'b0; ena = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rstep(input logic [2:0] b);
    step(b, $urandom_range(0, 4) == 0, $urandom_range(0, 15) != 0, "rnd");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         zlist [5];
    int         kind, plen, gap;
    logic [2:0] b;

    rst_n = 1'b0; ena = 1'b1; buzz_in = 3'b000; rd_en = 1'b0;
    model_reset();
    #12;
    check_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal 31-cycle pulse on zone 1
    pulse(1, 31, "t1");
    chk("t1_valid", 32'(evt_valid), 1);
    chk("t1_zone",  32'(evt_zone),  1);
    chk("t1_err",   32'(evt_err),   0);
    chk("t1_cnt",   32'(alarm_cnt), 1);
    step(3'b000, 1'b1, 1'b1, "t1_pop");

    // Short, upper-edge and stuck pulses on zone 2
    pulse(2, 10, "t2_short");
    chk("t2_short_err", 32'(evt_err), 1);
    chk("t2_short_cnt", 32'(alarm_cnt), 1);
    step(3'b000, 1'b1, 1'b1, "t2_pop");
    pulse(2, 32, "t2_edge");
    chk("t2_edge_err", 32'(evt_err), 0);
    chk("t2_edge_cnt", 32'(alarm_cnt), 2);
    step(3'b000, 1'b1, 1'b1, "t2_pop");
    hold(3'b010, 32, 1'b0, "t2_stuck");
    chk("t2_stuck_pre", 32'(evt_valid), 0);
    step(3'b010, 1'b0, 1'b1, "t2_stuck33");
    chk("t2_stuck_valid", 32'(evt_valid), 1);
    chk("t2_stuck_err", 32'(evt_err), 1);
    hold(3'b010, 3, 1'b1, "t2_stuck_tail");
    hold(3'b000, 3, 1'b0, "t2_stuck_drop");
    chk("t2_stuck_noevt", 32'(evt_valid), 0);

    // Multi-hot and zone switch mid-pulse
    step(3'b101, 1'b0, 1'b1, "t3_multi");
    chk("t3_multi_zone", 32'(evt_zone), 0);
    chk("t3_multi_err",  32'(evt_err), 1);
    step(3'b000, 1'b1, 1'b1, "t3_pop");
    hold(3'b100, 5, 1'b0, "t3_z3");
    hold(3'b010, 4, 1'b0, "t3_switch");
    chk("t3_sw_zone", 32'(evt_zone), 3);
    hold(3'b000, 2, 1'b0, "t3_clr");
    step(3'b000, 1'b1, 1'b1, "t3_pop");
    chk("t3_sw_single", 32'(evt_valid), 0);

    // Fill past capacity, then drain in order
    do_reset();
    zlist = '{1, 2, 3, 1, 2};
    for (int i = 0; i < 5; i++) pulse(zlist[i], 31, "t4_fill");
    chk("t4_full", 32'(fifo_full), 1);
    chk("t4_ovf",  32'(overflow), 1);
    chk("t4_cnt",  32'(alarm_cnt), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_order", 32'(evt_zone), 32'(zlist[i]));
      step(3'b000, 1'b1, 1'b1, "t4_pop");
    end
    chk("t4_empty", 32'(evt_valid), 0);

    // Push and pop on the same edge while full
    do_reset();
    for (int i = 0; i < 4; i++) pulse(zlist[i], 31, "t5_fill");
    hold(3'b100, 31, 1'b0, "t5_pulse");
    step(3'b000, 1'b1, 1'b1, "t5_pushpop");
    chk("t5_full", 32'(fifo_full), 1);
    chk("t5_ovf",  32'(overflow), 0);
    chk("t5_head", 32'(evt_zone), 2);
    hold(3'b000, 4, 1'b1, "t5_drain");

    // Enable low for 20 cycles in the middle of a pulse
    hold(3'b001, 10, 1'b0, "t6_a");
    for (int i = 0; i < 20; i++) step(3'($urandom_range(0, 7)), 1'b1, 1'b0, "t6_frozen");
    hold(3'b001, 21, 1'b0, "t6_b");
    step(3'b000, 1'b0, 1'b1, "t6_end");
    chk("t6_err", 32'(evt_err), 0);

    // Asynchronous reset mid-pulse, with an event pending
    hold(3'b010, 12, 1'b0, "t7_pulse");
    #2;
    rst_n = 1'b0; buzz_in = 3'b000;
    #1;
    model_reset();
    chk("t7_arst_valid", 32'(evt_valid), 0);
    check_outputs("t7_arst");
    @(negedge clk);
    rst_n = 1'b1;
    hold(3'b000, 5, 1'b0, "t7_after");
    #2;
    rst_n = 1'b0; buzz_in = 3'b100;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    hold(3'b100, 30, 1'b0, "t7_held");
    step(3'b000, 1'b0, 1'b1, "t7_held_end");
    chk("t7_held_zone", 32'(evt_zone), 3);

    // Random pulses, glitches and reads
    do_reset();
    for (int i = 0; i < 45; i++) begin
      kind = $urandom_range(0, 9);
      plen = $urandom_range(26, 36);
      b    = 3'b001 << $urandom_range(0, 2);
      if (kind == 0) begin
        case ($urandom_range(0, 3))
          0: b = 3'b011;
          1: b = 3'b101;
          2: b = 3'b110;
          default: b = 3'b111;
        endcase
        plen = $urandom_range(1, 3);
      end
      for (int c = 0; c < plen; c++) rstep(b);
      if (kind == 1) begin
        b = (b == 3'b001) ? 3'b100 : 3'b001;
        for (int c = 0; c < 3; c++) rstep(b);
      end
      gap = $urandom_range(0, 3);
      for (int c = 0; c < gap; c++) rstep(3'b000);
      rstep(3'b000);
    end
    hold(3'b000, 6, 1'b1, "rnd_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
